// File: rtl/count_mod_updown.sv
// count_mod_updown: modulo up/down counter with programmable start delay.
// Range 0..MODULUS-1, runtime direction, synchronous clear/load (clear wins),
// registered wrap pulse and combinational terminal-count flag for chaining.
// Optional build macro COUNT_SATURATE_EN: pin at the terminal value instead
// of wrapping; oWrap then never asserts.
module count_mod_updown #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MODULUS   = 256,
  parameter int unsigned     START_DLY = 0
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iEnable,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  input  logic             iClear,
  output logic [WIDTH-1:0] oCount,
  output logic             oWrap,
  output logic             oTc,
  output logic             oRunning
);

  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("count_mod_updown: MODULUS must be in 2..2**WIDTH");
  end
  if (START_DLY > 255) begin : g_bad_dly
    $error("count_mod_updown: START_DLY must be in 0..255");
  end

  localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);
  localparam logic [7:0]       DLY_LAST = 8'(START_DLY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RUN
  } state_t;

  state_t     state;
  logic [7:0] dly_cnt;

  // Terminal count is combinational so a downstream counter can gate its
  // enable in the same cycle.
  always_comb begin
    oTc = oRunning & ((iUp & (oCount == TOP)) | (~iUp & (oCount == '0)));
  end

  // Count register: clear beats load beats step; steps only while in RUN.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oCount <= '0;
      oWrap  <= 1'b0;
    end else begin
      oWrap <= 1'b0;
      if (iClear) begin
        oCount <= '0;
      end else if (iLoad) begin
        oCount <= (iLoadVal > TOP) ? TOP : iLoadVal;
      end else if (state == S_RUN && iEnable) begin
        if (iUp) begin
          if (oCount == TOP) begin
`ifdef COUNT_SATURATE_EN
            oCount <= TOP;
`else
            oCount <= '0;
            oWrap  <= 1'b1;
`endif
          end else begin
            oCount <= oCount + WIDTH'(1);
          end
        end else begin
          if (oCount == '0) begin
`ifdef COUNT_SATURATE_EN
            oCount <= '0;
`else
            oCount <= TOP;
            oWrap  <= 1'b1;
`endif
          end else begin
            oCount <= oCount - WIDTH'(1);
          end
        end
      end
    end
  end

  // Control FSM: IDLE -> (WAIT for START_DLY edges) -> RUN; enable low aborts.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state    <= S_IDLE;
      dly_cnt  <= '0;
      oRunning <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          dly_cnt <= '0;
          if (iEnable) begin
            if (START_DLY == 0) begin
              state    <= S_RUN;
              oRunning <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!iEnable) begin
            state   <= S_IDLE;
            dly_cnt <= '0;
          end else begin
            // dly_cnt reaches START_DLY on the same edge that enters RUN
            dly_cnt <= dly_cnt + 8'd1;
            if (dly_cnt == DLY_LAST) begin
              state    <= S_RUN;
              oRunning <= 1'b1;
            end
          end
        end
        S_RUN: begin
          dly_cnt <= '0;
          if (!iEnable) begin
            state    <= S_IDLE;
            oRunning <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          dly_cnt  <= '0;
          oRunning <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_mod_updown.sv
// tb_count_mod_updown: three counter instances (mod 10 / no delay, mod 10 /
// delay 3, mod 16 / delay 2) share one stimulus stream and are compared every
// cycle against an arithmetic reference model. Honours COUNT_SATURATE_EN.
module tb_count_mod_updown;

`ifdef COUNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int N = 3;
  localparam int CFG_MOD [N] = '{10, 10, 16};
  localparam int CFG_DLY [N] = '{0, 3, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       clr = 1'b0;
  logic       ld  = 1'b0;
  logic [3:0] ldv = '0;

  logic [3:0] d_cnt  [N];
  logic       d_wrap [N];
  logic       d_tc   [N];
  logic       d_run  [N];

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 waiting (m_left edges remain), 2 running
  int m_cnt   [N];
  bit m_wrap  [N];
  int m_phase [N];
  int m_left  [N];

  always #5 clk = ~clk;

  count_mod_updown #(.WIDTH(4), .MODULUS(10), .START_DLY(0)) u_d0 (
    .iClock(clk), .iReset(rst), .iEnable(en), .iUp(up), .iLoad(ld),
    .iLoadVal(ldv), .iClear(clr), .oCount(d_cnt[0]), .oWrap(d_wrap[0]),
    .oTc(d_tc[0]), .oRunning(d_run[0]));

  count_mod_updown #(.WIDTH(4), .MODULUS(10), .START_DLY(3)) u_d3 (
    .iClock(clk), .iReset(rst), .iEnable(en), .iUp(up), .iLoad(ld),
    .iLoadVal(ldv), .iClear(clr), .oCount(d_cnt[1]), .oWrap(d_wrap[1]),
    .oTc(d_tc[1]), .oRunning(d_run[1]));

  count_mod_updown #(.WIDTH(4), .MODULUS(16), .START_DLY(2)) u_m16 (
    .iClock(clk), .iReset(rst), .iEnable(en), .iUp(up), .iLoad(ld),
    .iLoadVal(ldv), .iClear(clr), .oCount(d_cnt[2]), .oWrap(d_wrap[2]),
    .oTc(d_tc[2]), .oRunning(d_run[2]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]   = 0;
      m_wrap[i]  = 1'b0;
      m_phase[i] = 0;
      m_left[i]  = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < N; i++) begin
      int top;
      top       = CFG_MOD[i] - 1;
      m_wrap[i] = 1'b0;
      if (clr) begin
        m_cnt[i] = 0;
      end else if (ld) begin
        m_cnt[i] = (int'(ldv) > top) ? top : int'(ldv);
      end else if (m_phase[i] == 2 && en) begin
        if (up && m_cnt[i] == top) begin
          m_cnt[i]  = SAT ? top : 0;
          m_wrap[i] = !SAT;
        end else if (!up && m_cnt[i] == 0) begin
          m_cnt[i]  = SAT ? 0 : top;
          m_wrap[i] = !SAT;
        end else begin
          m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
        end
      end
      if (!en) begin
        m_phase[i] = 0;
      end else if (m_phase[i] == 0) begin
        m_left[i]  = CFG_DLY[i];
        m_phase[i] = (CFG_DLY[i] == 0) ? 2 : 1;
      end else if (m_phase[i] == 1) begin
        m_left[i]--;
        if (m_left[i] == 0) m_phase[i] = 2;
      end
    end
  endfunction

  task automatic check_regs();
    for (int i = 0; i < N; i++) begin
      check($sformatf("count%0d", i), int'(d_cnt[i]), m_cnt[i]);
      check($sformatf("wrap%0d", i), int'(d_wrap[i]), int'(m_wrap[i]));
      check($sformatf("running%0d", i), int'(d_run[i]), (m_phase[i] == 2) ? 1 : 0);
    end
  endtask

  task automatic check_tc();
    for (int i = 0; i < N; i++) begin
      bit exp_tc;
      exp_tc = (m_phase[i] == 2) &&
               ((up && m_cnt[i] == CFG_MOD[i] - 1) || (!up && m_cnt[i] == 0));
      check($sformatf("tc%0d", i), int'(d_tc[i]), int'(exp_tc));
    end
  endtask

  // Apply inputs away from the edge, check oTc, then clock once and check.
  task automatic drive(input logic e, input logic u, input logic c,
                       input logic l, input logic [3:0] v);
    en  = e;
    up  = u;
    clr = c;
    ld  = l;
    ldv = v;
    #1;
    check_tc();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  // Pulse reset between edges and confirm outputs clear without a clock.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_count", int'(d_cnt[0]), 0);
    check("async_running", int'(d_run[0]), 0);
    check("async_wrap", int'(d_wrap[0]), 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    check_regs();
    rst = 1'b0;
    #1;

    // Acceptance edge k, then observe start-delay latency on the delay-3 unit
    drive(1, 1, 0, 0, 0);
    check("d3_running_k", int'(d_run[1]), 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    check("d3_running_k3", int'(d_run[1]), 1);
    check("d3_count_k3", int'(d_cnt[1]), 0);
    drive(1, 1, 0, 0, 0);
    check("d3_count_k4", int'(d_cnt[1]), 1);
    for (int n = 0; n < 12; n++) drive(1, 1, 0, 0, 0);

    // Stop, then abort a WAIT and restart the full delay
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int n = 0; n < 5; n++) drive(1, 1, 0, 0, 0);

    // Load 2 and count down through the wrap, then reverse at the top
    drive(1, 0, 0, 1, 4'd2);
    check("load2", int'(d_cnt[0]), 2);
    for (int n = 0; n < 3; n++) drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 4'd5);
    drive(1, 1, 0, 0, 0);
    check("rev_at5", int'(d_cnt[0]), 6);
    check("rev_at5_wrap", int'(d_wrap[0]), 0);

    // Clear beats load; oversize load clamps
    drive(1, 1, 0, 1, 4'd9);
    drive(1, 1, 1, 1, 4'd4);
    check("clr_over_ld", int'(d_cnt[0]), 0);
    check("clr_no_wrap", int'(d_wrap[0]), 0);
    drive(1, 1, 0, 1, 4'd12);
    check("clamp", int'(d_cnt[0]), 9);

    // Pin at the top for a while (wraps or saturates depending on build)
    for (int n = 0; n < 5; n++) drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 4'd1);
    for (int n = 0; n < 4; n++) drive(1, 0, 0, 0, 0);

    // Reset in the middle of RUN, then restart
    drive(1, 1, 0, 1, 4'd7);
    async_reset();
    for (int n = 0; n < 6; n++) drive(1, 1, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0, v);
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
